// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the byte/word memory access unit.
// The pair address always points at the odd (high) byte of a 16-bit pair.
package mem_access_unit_pkg;

   localparam int ADDR_W_DEFAULT = 14;
   localparam int DATA_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RESP
   } state_t;

   typedef logic [31:0] addr_wide_t;

   // Forcing bit 0 high can never carry, so the pair address cannot wrap.
   function automatic addr_wide_t pair_addr(input addr_wide_t addr);
      return addr | addr_wide_t'(1);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response handshake plus the 16-bit pair memory port.
// The slave modport is the unit; the master modport is the core and memory side.
interface mem_access_unit_if
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic              req_byte;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_byte, req_addr, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req_valid, req_we, req_byte, req_addr, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/word load-store unit over a 16-bit pair memory; byte stores are done
// as read-modify-write of the pair, misaligned word accesses error out.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);

   state_t            state_reg;
   logic              addr_lsb_reg;
   logic [7:0]        wbyte_reg;
   logic              we_reg;
   logic              byte_reg;
   logic              req_ready_reg;
   logic              resp_valid_reg;
   logic              resp_err_reg;
   logic [DATA_W-1:0] resp_rdata_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic              mem_we_reg;

   logic [ADDR_W-1:0] pair_next;
   logic              accept;
   logic              misaligned;
   logic [7:0]        rd_byte;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merge_data;

   always_comb begin
      pair_next  = ADDR_W'(pair_addr(addr_wide_t'(bus.req_addr)));
      accept     = bus.req_valid && req_ready_reg;
      misaligned = !bus.req_byte && !bus.req_addr[0];
      rd_byte    = addr_lsb_reg ? bus.mem_rdata[DATA_W-1:8] : bus.mem_rdata[7:0];
      load_data  = byte_reg ? DATA_W'(rd_byte) : bus.mem_rdata;
      // Odd address owns the high byte of the pair, even address the low byte.
      merge_data = addr_lsb_reg ? {wbyte_reg, bus.mem_rdata[7:0]}
                                : {bus.mem_rdata[DATA_W-1:8], wbyte_reg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         addr_lsb_reg   <= 1'b0;
         wbyte_reg      <= '0;
         we_reg         <= 1'b0;
         byte_reg       <= 1'b0;
         req_ready_reg  <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_rdata_reg <= '0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         mem_we_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               req_ready_reg <= 1'b1;
               if (accept) begin
                  req_ready_reg <= 1'b0;
                  addr_lsb_reg  <= bus.req_addr[0];
                  wbyte_reg     <= bus.req_wdata[7:0];
                  we_reg        <= bus.req_we;
                  byte_reg      <= bus.req_byte;
                  if (misaligned) begin
                     state_reg      <= ST_RESP;
                     resp_valid_reg <= 1'b1;
                     resp_err_reg   <= 1'b1;
                     resp_rdata_reg <= '0;
                  end else if (bus.req_we && !bus.req_byte) begin
                     state_reg     <= ST_WR;
                     mem_addr_reg  <= pair_next;
                     mem_wdata_reg <= bus.req_wdata;
                     mem_we_reg    <= 1'b1;
                  end else begin
                     state_reg     <= ST_RD;
                     mem_addr_reg  <= pair_next;
                     mem_wdata_reg <= '0;
                     mem_we_reg    <= 1'b0;
                  end
               end
            end
            ST_RD: begin
               // Only byte stores reach RD with we set; they continue to the write.
               if (we_reg) begin
                  state_reg     <= ST_WR;
                  mem_wdata_reg <= merge_data;
                  mem_we_reg    <= 1'b1;
               end else begin
                  state_reg      <= ST_RESP;
                  mem_addr_reg   <= '0;
                  resp_valid_reg <= 1'b1;
                  resp_err_reg   <= 1'b0;
                  resp_rdata_reg <= load_data;
               end
            end
            ST_WR: begin
               state_reg      <= ST_RESP;
               mem_addr_reg   <= '0;
               mem_wdata_reg  <= '0;
               mem_we_reg     <= 1'b0;
               resp_valid_reg <= 1'b1;
               resp_err_reg   <= 1'b0;
               resp_rdata_reg <= '0;
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  state_reg      <= ST_IDLE;
                  resp_valid_reg <= 1'b0;
                  resp_err_reg   <= 1'b0;
                  resp_rdata_reg <= '0;
                  req_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_err   = resp_err_reg;
   assign bus.resp_rdata = resp_rdata_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_wdata  = mem_wdata_reg;
   assign bus.mem_we     = mem_we_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: byte-addressed memory model, vector
// table of transactions, plus hand sequences for backpressure and reset.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int AW = 14;
   localparam int DW = 16;

   logic clk;
   logic rst;
   logic mem_clear;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]    mem_bytes [0:(1<<AW)-1];
   int            we_pulses;
   int            addr_active;
   logic [AW-1:0] last_we_addr;
   logic [DW-1:0] last_we_data;

   assign bus.mem_rdata = (bus.mem_addr == '0) ? '0 :
                          {mem_bytes[bus.mem_addr], mem_bytes[bus.mem_addr - AW'(1)]};

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < (1 << AW); i++) mem_bytes[i] <= 8'h00;
         we_pulses    <= 0;
         addr_active  <= 0;
         last_we_addr <= '0;
         last_we_data <= '0;
      end else begin
         if (bus.mem_we) begin
            mem_bytes[bus.mem_addr]          <= bus.mem_wdata[15:8];
            mem_bytes[bus.mem_addr - AW'(1)] <= bus.mem_wdata[7:0];
            we_pulses    <= we_pulses + 1;
            last_we_addr <= bus.mem_addr;
            last_we_data <= bus.mem_wdata;
         end
         if (bus.mem_addr != '0) addr_active <= addr_active + 1;
      end
   end

   int total;
   int bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts at a negedge, ends at a negedge after the response is consumed.
   task automatic run_txn(input logic we, input logic byt, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                          output logic er, output int lat, output int wes);
      int n;
      int we0;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_byte   = byt;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.resp_ready = 1'b1;
      we0 = we_pulses;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      rd  = bus.resp_rdata;
      er  = bus.resp_err;
      wes = we_pulses - we0;
      @(negedge clk);
   endtask

   // Releases reset just after a rising edge, then checks the ready timing.
   task automatic release_reset(input string tag);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check({tag, "_ready_c1"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_valid_c1"}, 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      check({tag, "_ready_c2"}, 32'(bus.req_ready), 32'd1);
   endtask

   typedef struct {
      logic          we;
      logic          byt;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_lat;
      int            exp_wes;
      logic [AW-1:0] exp_pa;
      logic [DW-1:0] exp_pw;
   } vec_t;

   vec_t vecs [14];

   initial begin
      logic [DW-1:0] rd;
      logic          er;
      int            lat;
      int            wes;
      int            act0;
      int            we0;
      logic [DW-1:0] held_rd;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      mem_clear      = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_byte   = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;

      //           we    byt   addr      wdata     rdata     err   lat wes pa        pw
      vecs[0]  = '{1'b1, 1'b0, 14'h0011, 16'hBEEF, 16'h0000, 1'b0, 2, 1, 14'h0011, 16'hBEEF};
      vecs[1]  = '{1'b0, 1'b0, 14'h0011, 16'h0000, 16'hBEEF, 1'b0, 2, 0, 14'h0000, 16'h0000};
      vecs[2]  = '{1'b1, 1'b1, 14'h0010, 16'h005A, 16'h0000, 1'b0, 3, 1, 14'h0011, 16'hBE5A};
      vecs[3]  = '{1'b0, 1'b1, 14'h0011, 16'h0000, 16'h00BE, 1'b0, 2, 0, 14'h0000, 16'h0000};
      vecs[4]  = '{1'b0, 1'b1, 14'h0010, 16'h0000, 16'h005A, 1'b0, 2, 0, 14'h0000, 16'h0000};
      vecs[5]  = '{1'b0, 1'b0, 14'h0010, 16'h0000, 16'h0000, 1'b1, 1, 0, 14'h0000, 16'h0000};
      vecs[6]  = '{1'b1, 1'b0, 14'h0010, 16'h1111, 16'h0000, 1'b1, 1, 0, 14'h0000, 16'h0000};
      vecs[7]  = '{1'b1, 1'b1, 14'h0011, 16'h1234, 16'h0000, 1'b0, 3, 1, 14'h0011, 16'h345A};
      vecs[8]  = '{1'b0, 1'b0, 14'h0011, 16'h0000, 16'h345A, 1'b0, 2, 0, 14'h0000, 16'h0000};
      vecs[9]  = '{1'b1, 1'b1, 14'h3FFE, 16'hFF77, 16'h0000, 1'b0, 3, 1, 14'h3FFF, 16'h0077};
      vecs[10] = '{1'b0, 1'b0, 14'h3FFF, 16'h0000, 16'h0077, 1'b0, 2, 0, 14'h0000, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 14'h3FFF, 16'hA1B2, 16'h0000, 1'b0, 2, 1, 14'h3FFF, 16'hA1B2};
      vecs[12] = '{1'b0, 1'b1, 14'h3FFE, 16'h0000, 16'h00B2, 1'b0, 2, 0, 14'h0000, 16'h0000};
      vecs[13] = '{1'b0, 1'b1, 14'h3FFF, 16'h0000, 16'h00A1, 1'b0, 2, 0, 14'h0000, 16'h0000};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready",  32'(bus.req_ready),  32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_err",   32'(bus.resp_err),   32'd0);
      check("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
      check("rst_mem_we",     32'(bus.mem_we),     32'd0);
      check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
      check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
      mem_clear = 1'b0;
      release_reset("init");

      // Vector table
      for (int v = 0; v < 14; v++) begin
         act0 = addr_active;
         run_txn(vecs[v].we, vecs[v].byt, vecs[v].addr, vecs[v].wdata, rd, er, lat, wes);
         $display("txn %0d: we=%0b byte=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d writes=%0d",
                  v, vecs[v].we, vecs[v].byt, vecs[v].addr, vecs[v].wdata, rd, er, lat, wes);
         check($sformatf("v%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rdata));
         check($sformatf("v%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
         check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
         check($sformatf("v%0d_we_pulses", v), 32'(wes), 32'(vecs[v].exp_wes));
         if (vecs[v].exp_wes != 0) begin
            check($sformatf("v%0d_pair_addr", v), 32'(last_we_addr), 32'(vecs[v].exp_pa));
            check($sformatf("v%0d_pair_wdata", v), 32'(last_we_data), 32'(vecs[v].exp_pw));
         end
         if (vecs[v].exp_err) begin
            check($sformatf("v%0d_no_mem_addr", v), 32'(addr_active - act0), 32'd0);
         end
      end

      // Backpressure: response held while resp_ready stays low
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_byte   = 1'b0;
      bus.req_addr   = 14'h0011;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("hold_latency", 32'(lat), 32'd2);
      held_rd = bus.resp_rdata;
      check("hold_rdata_first", 32'(held_rd), 32'h345A);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("hold%0d_valid", c), 32'(bus.resp_valid), 32'd1);
         check($sformatf("hold%0d_rdata", c), 32'(bus.resp_rdata), 32'h345A);
         check($sformatf("hold%0d_err", c),   32'(bus.resp_err),   32'd0);
         check($sformatf("hold%0d_ready", c), 32'(bus.req_ready),  32'd0);
      end
      $display("txn hold: word load addr=0011 held 5 cycles rdata=%h", bus.resp_rdata);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("hold_release_valid", 32'(bus.resp_valid), 32'd0);
      check("hold_release_ready", 32'(bus.req_ready),  32'd1);

      // Reset during RD of a byte store: no write, no response
      we0 = we_pulses;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_byte  = 1'b1;
      bus.req_addr  = 14'h0011;
      bus.req_wdata = 16'h0099;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rd_state_addr", 32'(bus.mem_addr), 32'h0011);
      check("rd_state_we",   32'(bus.mem_we),   32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rstrd_mem_we",     32'(bus.mem_we),     32'd0);
      check("rstrd_resp_valid", 32'(bus.resp_valid), 32'd0);
      release_reset("rstrd");
      check("rstrd_no_write", 32'(we_pulses - we0), 32'd0);
      $display("txn reset-in-RD: byte store addr=0011 abandoned, writes=%0d", we_pulses - we0);
      run_txn(1'b0, 1'b0, 14'h0011, 16'h0000, rd, er, lat, wes);
      $display("txn after reset: word load addr=0011 -> rdata=%h err=%0b lat=%0d", rd, er, lat);
      check("post_rst_rdata",   32'(rd),  32'h345A);
      check("post_rst_latency", 32'(lat), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
